// File: rtl/temp_status_monitor.sv
// Multi-channel temperature status monitor: per-channel hysteresis/persistence
// classification with latched extremes and a round-robin 15-pin status display.
module temp_status_monitor #(
    parameter int WIDTH     = 8,
    parameter int N_CH      = 4,
    parameter int FREEZE_TH = -30,
    parameter int COLD_TH   = -16,
    parameter int WARM_TH   = 45,
    parameter int HOT_TH    = 60,
    parameter int HYST      = 3,
    parameter int PERSIST   = 3,
    parameter int DISP_HOLD = 4,
    localparam int SEL_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clock_in,
    input  logic                    reset_n_in,
    input  logic [N_CH*WIDTH-1:0]   temperature_in,
    input  logic [N_CH-1:0]         sample_valid_in,
    input  logic                    alarm_ack_in,
    output logic [14:0]             display_pins_out,
    output logic [SEL_W-1:0]        channel_sel_out,
    output logic [3*N_CH-1:0]       state_out,
    output logic                    alarm_out
);
    localparam int CNT_W  = $clog2(PERSIST + 1);
    localparam int HOLD_W = (DISP_HOLD > 1) ? $clog2(DISP_HOLD) : 1;

    typedef enum logic [2:0] {
        ST_RESET    = 3'd0,
        ST_OKAY     = 3'd1,
        ST_COLD     = 3'd2,
        ST_WARM     = 3'd3,
        ST_TOO_COLD = 3'd4,
        ST_TOO_WARM = 3'd5
    } state_e;

    localparam logic [14:0] GLYPH_R     = 15'b001110001001101;
    localparam logic [14:0] GLYPH_O     = 15'b001010100010101;
    localparam logic [14:0] GLYPH_C     = 15'b001010100000001;
    localparam logic [14:0] GLYPH_W     = 15'b001011001010100;
    localparam logic [14:0] GLYPH_C_DOT = 15'b001010100100001;
    localparam logic [14:0] GLYPH_W_DOT = 15'b001011001110100;

    state_e           state_q [N_CH];
    state_e           state_d [N_CH];
    logic [CNT_W-1:0] fcnt_q  [N_CH];
    logic [CNT_W-1:0] fcnt_d  [N_CH];
    logic [CNT_W-1:0] hcnt_q  [N_CH];
    logic [CNT_W-1:0] hcnt_d  [N_CH];
    int               samp    [N_CH];

    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [14:0]       pins_q, pins_d;
    logic              alarm;
    logic [SEL_W-1:0]  alarm_idx;

    function automatic logic is_alarm(state_e s);
        return (s == ST_TOO_COLD) || (s == ST_TOO_WARM);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] c);
        return (int'(c) >= PERSIST) ? c : c + 1'b1;
    endfunction

    // Normal-band classification; COLD/WARM only release once past the hysteresis band.
    function automatic state_e classify(state_e cur, int t);
        case (cur)
            ST_COLD: begin
                if (t <= COLD_TH + HYST) return ST_COLD;
                else if (t > WARM_TH)    return ST_WARM;
                else                     return ST_OKAY;
            end
            ST_WARM: begin
                if (t > WARM_TH - HYST)  return ST_WARM;
                else if (t <= COLD_TH)   return ST_COLD;
                else                     return ST_OKAY;
            end
            default: begin
                if (t <= COLD_TH)        return ST_COLD;
                else if (t > WARM_TH)    return ST_WARM;
                else                     return ST_OKAY;
            end
        endcase
    endfunction

    function automatic logic [14:0] glyph(state_e s);
        case (s)
            ST_OKAY:     return GLYPH_O;
            ST_COLD:     return GLYPH_C;
            ST_WARM:     return GLYPH_W;
            ST_TOO_COLD: return GLYPH_C_DOT;
            ST_TOO_WARM: return GLYPH_W_DOT;
            default:     return GLYPH_R;
        endcase
    endfunction

    always_comb begin : sample_extend
        for (int i = 0; i < N_CH; i++) begin
            samp[i] = int'($signed(temperature_in[WIDTH*i +: WIDTH]));
        end
    end

    always_comb begin : channel_next
        for (int i = 0; i < N_CH; i++) begin
            // NOTE: every combinational output gets a default first so no path infers a latch.
            state_d[i] = state_q[i];
            fcnt_d[i]  = fcnt_q[i];
            hcnt_d[i]  = hcnt_q[i];
            if (is_alarm(state_q[i])) begin
                if (alarm_ack_in) begin
                    state_d[i] = ST_RESET;
                    fcnt_d[i]  = '0;
                    hcnt_d[i]  = '0;
                end
            end else if (sample_valid_in[i]) begin
                fcnt_d[i] = (samp[i] <= FREEZE_TH) ? sat_inc(fcnt_q[i]) : '0;
                hcnt_d[i] = (samp[i] > HOT_TH)     ? sat_inc(hcnt_q[i]) : '0;
                if ((samp[i] <= FREEZE_TH) && (int'(fcnt_q[i]) + 1 >= PERSIST)) begin
                    state_d[i] = ST_TOO_COLD;
                end else if ((samp[i] > HOT_TH) && (int'(hcnt_q[i]) + 1 >= PERSIST)) begin
                    state_d[i] = ST_TOO_WARM;
                end else begin
                    state_d[i] = classify(state_q[i], samp[i]);
                end
            end
        end
    end

    // Scan downward so the lowest-index alarmed channel wins.
    always_comb begin : alarm_scan
        alarm     = 1'b0;
        alarm_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (is_alarm(state_q[i])) begin
                alarm     = 1'b1;
                alarm_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin : display_next
        sel_d  = sel_q;
        hold_d = hold_q;
        if (alarm) begin
            sel_d  = alarm_idx;
            hold_d = '0;
        end else if (hold_q == HOLD_W'(DISP_HOLD - 1)) begin
            hold_d = '0;
            sel_d  = (sel_q == SEL_W'(N_CH - 1)) ? '0 : sel_q + 1'b1;
        end else begin
            hold_d = hold_q + 1'b1;
        end
        pins_d = glyph(state_q[sel_d]);
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= ST_RESET;
                fcnt_q[i]  <= '0;
                hcnt_q[i]  <= '0;
            end
            sel_q  <= '0;
            hold_q <= '0;
            pins_q <= GLYPH_R;
        end else begin
            // NOTE: non-blocking updates keep every register sampling pre-edge values.
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                fcnt_q[i]  <= fcnt_d[i];
                hcnt_q[i]  <= hcnt_d[i];
            end
            sel_q  <= sel_d;
            hold_q <= hold_d;
            pins_q <= pins_d;
        end
    end

    always_comb begin : pack_outputs
        state_out = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_out[3*i +: 3] = state_q[i];
        end
    end

    assign alarm_out        = alarm;
    assign channel_sel_out  = sel_q;
    assign display_pins_out = pins_q;

endmodule
